sdf_r2_stage: RTL and testbench

- One parametrised radix-2 single-path delay feedback (SDF) stage for the streaming FFT pipeline.
- Owns its N/2 delay line, sample counter, phase sequencing, twiddle-index generation, valid handshake and registered output.
- Replaces hand-sized per-stage butterflies. Stages chain output-to-input, with each stage using FFT_N halved from the previous one.
- Adds run-time forward/inverse mode and optional rounding.

---
 rtl/fft_pkg.sv | 28 ++
 rtl/sdf_delay_line.sv | 41 ++++
 rtl/sdf_r2_stage.sv | 158 +++++++++++++++
 tb/tb_sdf_r2_stage.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types and defaults for the streaming radix-2 SDF FFT pipeline.
// Holds phase encoding, legacy state codes, width helper and default widths.
package fft_pkg;

    localparam int DW_DEF      = 15;
    localparam int TW_W_DEF    = 8;
    localparam int TW_FRAC_DEF = 6;

    typedef enum logic {
        PH_FILL = 1'b0,
        PH_BFLY = 1'b1
    } phase_e;

    // Older per-stage controllers exported these codes; kept so that
    // existing monitors keep compiling against the package.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FIRST   = 2'd1,
        SECOND  = 2'd2,
        WAITING = 2'd3
    } legacy_state_e;

    // Counter / twiddle index width; at least one bit so FFT_N = 2 works.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sdf_delay_line.sv
// Enable-gated shift register used as the SDF feedback memory.
// Ports: clk, rst (async high), en (shift), tail (write data), head (oldest).
module sdf_delay_line
    import fft_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] tail,
    output logic [W-1:0] head
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (en) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                mem_d[i] = mem_q[i+1];
            end
            mem_d[DEPTH-1] = tail;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign head = mem_q[0];

endmodule

// File: rtl/sdf_r2_stage.sv
// One radix-2 single-path delay feedback FFT stage (DIF ordering).
// Ports: clk, rst (async high), in_valid/in_r/in_i/inv sample in,
// tw_idx out / tw_r,tw_i in (combinational ROM), out_valid/out_r/out_i.
module sdf_r2_stage
    import fft_pkg::*;
#(
    parameter int FFT_N     = 32,
    parameter int DW        = DW_DEF,
    parameter int TW_W      = TW_W_DEF,
    parameter int TW_FRAC   = TW_FRAC_DEF,
    parameter int TW_STRIDE = 1,
    parameter int ROUND     = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [DW-1:0]             in_r,
    input  logic [DW-1:0]             in_i,
    input  logic                      inv,
    output logic [cnt_w(FFT_N)-1:0]   tw_idx,
    input  logic [TW_W-1:0]           tw_r,
    input  logic [TW_W-1:0]           tw_i,
    output logic                      out_valid,
    output logic [DW:0]               out_r,
    output logic [DW:0]               out_i
);

    localparam int HALF = FFT_N / 2;
    localparam int CW   = cnt_w(FFT_N);
    localparam int PW   = DW + TW_W + 2;

    localparam logic [CW-1:0] CNT_LAST = CW'(FFT_N - 1);
    localparam logic [CW-1:0] STRIDE   = CW'(TW_STRIDE);
    localparam logic signed [PW-1:0] RND =
        (ROUND != 0) ? (PW'(1) << (TW_FRAC - 1)) : '0;

    logic [CW-1:0]     cnt_q, cnt_d;
    logic              primed_q, primed_d;
    logic              inv_q, inv_d;
    logic              out_valid_q, out_valid_d;
    logic signed [DW:0] out_r_q, out_r_d;
    logic signed [DW:0] out_i_q, out_i_d;

    phase_e             phase;
    logic signed [DW:0] a_r, a_i;
    logic signed [DW:0] d_r, d_i;
    logic signed [DW:0] tail_r, tail_i;
    logic [2*DW+1:0]    head_w, tail_w;

    logic signed [TW_W:0] w_r, w_i_raw, w_i;
    logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
    logic signed [PW-1:0] m_r, m_i;
    logic signed [DW:0]   mul_r, mul_i;
    logic                 unused_bits;

    // Counter MSB doubles as the phase flag.
    assign phase = phase_e'(cnt_q[CW-1]);

    assign a_r = {in_r[DW-1], in_r};
    assign a_i = {in_i[DW-1], in_i};

    assign {d_r, d_i} = head_w;
    assign tail_w     = {tail_r, tail_i};

    sdf_delay_line #(
        .DEPTH (HALF),
        .W     (2 * DW + 2)
    ) u_delay (
        .clk  (clk),
        .rst  (rst),
        .en   (in_valid),
        .tail (tail_w),
        .head (head_w)
    );

    // Product in CW bits wraps the index mod FFT_N for free.
    assign tw_idx = (phase == PH_FILL) ? cnt_q * STRIDE : '0;

    // One extra bit so negating the imaginary twiddle never overflows.
    assign w_r     = {tw_r[TW_W-1], tw_r};
    assign w_i_raw = {tw_i[TW_W-1], tw_i};
    assign w_i     = inv_q ? -w_i_raw : w_i_raw;

    assign p_rr = PW'(d_r) * PW'(w_r);
    assign p_ii = PW'(d_i) * PW'(w_i);
    assign p_ri = PW'(d_r) * PW'(w_i);
    assign p_ir = PW'(d_i) * PW'(w_r);

    assign m_r = p_rr - p_ii + RND;
    assign m_i = p_ri + p_ir + RND;

    assign mul_r = m_r[TW_FRAC+DW:TW_FRAC];
    assign mul_i = m_i[TW_FRAC+DW:TW_FRAC];

    // |W| <= 1 keeps the dropped high bits redundant sign copies.
    assign unused_bits = ^{m_r[PW-1:TW_FRAC+DW+1], m_r[TW_FRAC-1:0],
                           m_i[PW-1:TW_FRAC+DW+1], m_i[TW_FRAC-1:0]};

    always_comb begin
        cnt_d       = cnt_q;
        primed_d    = primed_q;
        inv_d       = inv_q;
        out_valid_d = 1'b0;
        out_r_d     = out_r_q;
        out_i_d     = out_i_q;
        tail_r      = a_r;
        tail_i      = a_i;
        if (in_valid) begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == '0) begin
                inv_d = inv;
            end
            // A completed frame leaves valid differences in the delay.
            if (cnt_q == CNT_LAST) begin
                primed_d = 1'b1;
            end
            unique case (phase)
                PH_FILL: begin
                    out_r_d     = mul_r;
                    out_i_d     = mul_i;
                    out_valid_d = primed_q;
                    tail_r      = a_r;
                    tail_i      = a_i;
                end
                PH_BFLY: begin
                    out_r_d     = d_r + a_r;
                    out_i_d     = d_i + a_i;
                    out_valid_d = 1'b1;
                    tail_r      = d_r - a_r;
                    tail_i      = d_i - a_i;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            primed_q    <= 1'b0;
            inv_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_r_q     <= '0;
            out_i_q     <= '0;
        end else begin
            cnt_q       <= cnt_d;
            primed_q    <= primed_d;
            inv_q       <= inv_d;
            out_valid_q <= out_valid_d;
            out_r_q     <= out_r_d;
            out_i_q     <= out_i_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_r     = out_r_q;
    assign out_i     = out_i_q;

endmodule

// File: tb/tb_sdf_r2_stage.sv
// Self-checking bench for sdf_r2_stage: directed scenarios plus random
// streams on an FFT_N=4 truncating stage and an FFT_N=32 rounding stage.
module tb_sdf_r2_stage;

    localparam int STR = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [14:0] in_r, in_i;
    logic        inv;

    logic [1:0]  tw_idx_a;
    logic [7:0]  tw_r_a, tw_i_a;
    logic        out_valid_a;
    logic [15:0] out_r_a, out_i_a;

    logic [4:0]  tw_idx_b;
    logic [7:0]  tw_r_b, tw_i_b;
    logic        out_valid_b;
    logic [15:0] out_r_b, out_i_b;

    logic signed [7:0] rom_ar [4];
    logic signed [7:0] rom_ai [4];
    logic signed [7:0] rom_br [32];
    logic signed [7:0] rom_bi [32];

    int xr [4096];
    int xi [4096];
    bit xinv [4096];
    int n_acc;

    int ncmp = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    assign tw_r_a = rom_ar[tw_idx_a];
    assign tw_i_a = rom_ai[tw_idx_a];
    assign tw_r_b = rom_br[tw_idx_b];
    assign tw_i_b = rom_bi[tw_idx_b];

    sdf_r2_stage #(
        .FFT_N(4), .DW(15), .TW_W(8), .TW_FRAC(6),
        .TW_STRIDE(STR), .ROUND(0)
    ) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .in_r(in_r), .in_i(in_i), .inv(inv),
        .tw_idx(tw_idx_a), .tw_r(tw_r_a), .tw_i(tw_i_a),
        .out_valid(out_valid_a), .out_r(out_r_a), .out_i(out_i_a)
    );

    sdf_r2_stage #(
        .FFT_N(32), .DW(15), .TW_W(8), .TW_FRAC(6),
        .TW_STRIDE(STR), .ROUND(1)
    ) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .in_r(in_r), .in_i(in_i), .inv(inv),
        .tw_idx(tw_idx_b), .tw_r(tw_r_b), .tw_i(tw_i_b),
        .out_valid(out_valid_b), .out_r(out_r_b), .out_i(out_i_b)
    );

    function automatic int w16(input int v);
        logic signed [15:0] t;
        t = v[15:0];
        return int'(t);
    endfunction

    function automatic int sx(input logic [15:0] v);
        return int'($signed(v));
    endfunction

    // Reference: accepted sample k of a stream restarted at reset.
    // Second half of a frame emits x[p-h]+x[p]; first half of the next
    // frame emits (x[p]-x[p+h]) of the previous frame times W^p.
    function automatic void model(input int nn, input bit rnd,
                                  input bit sel, input int k,
                                  output bit ev, output int er,
                                  output int ei);
        int h, p, f, base, dr, di, wr, wi, pr, pq, ti;
        h = nn / 2;
        p = k % nn;
        f = k / nn;
        ev = 1'b0;
        er = 0;
        ei = 0;
        if (p >= h) begin
            ev = 1'b1;
            er = w16(xr[k-h] + xr[k]);
            ei = w16(xi[k-h] + xi[k]);
        end else if (f > 0) begin
            base = (f - 1) * nn;
            dr = w16(xr[base+p] - xr[base+p+h]);
            di = w16(xi[base+p] - xi[base+p+h]);
            ti = (p * STR) % nn;
            if (sel) begin
                wr = int'(rom_br[ti]);
                wi = int'(rom_bi[ti]);
            end else begin
                wr = int'(rom_ar[ti]);
                wi = int'(rom_ai[ti]);
            end
            if (xinv[f*nn]) wi = -wi;
            pr = dr * wr - di * wi;
            pq = dr * wi + di * wr;
            if (rnd) begin
                pr = pr + 32;
                pq = pq + 32;
            end
            ev = 1'b1;
            er = w16(pr >>> 6);
            ei = w16(pq >>> 6);
        end
    endfunction

    // Every task starts and ends 1 time unit after a rising edge.
    task automatic cycle(input bit v, input int r, input int i,
                         input bit iv, output bit ova,
                         output int ora, output int oia);
        bit eva, evb;
        int era, eia, erb, eib, p, et;
        in_valid = v;
        in_r = 15'(r);
        in_i = 15'(i);
        inv = iv;
        p = n_acc % 4;
        et = (p < 2) ? p : 0;
        ncmp++;
        if (int'(tw_idx_a) !== et) begin
            nerr++;
            $display("FAIL tw_idx_a got %0d want %0d", tw_idx_a, et);
        end
        p = n_acc % 32;
        et = (p < 16) ? p : 0;
        ncmp++;
        if (int'(tw_idx_b) !== et) begin
            nerr++;
            $display("FAIL tw_idx_b got %0d want %0d", tw_idx_b, et);
        end
        eva = 1'b0; evb = 1'b0;
        era = 0; eia = 0; erb = 0; eib = 0;
        if (v) begin
            xr[n_acc] = w16(int'($signed(in_r)));
            xi[n_acc] = w16(int'($signed(in_i)));
            xinv[n_acc] = iv;
            model(4, 1'b0, 1'b0, n_acc, eva, era, eia);
            model(32, 1'b1, 1'b1, n_acc, evb, erb, eib);
            n_acc++;
        end
        @(posedge clk);
        #1;
        ncmp++;
        if (out_valid_a !== eva) begin
            nerr++;
            $display("FAIL valid_a got %0b want %0b", out_valid_a, eva);
        end else if (eva) begin
            ncmp++;
            if (sx(out_r_a) !== era || sx(out_i_a) !== eia) begin
                nerr++;
                $display("FAIL data_a got (%0d,%0d) want (%0d,%0d)",
                         sx(out_r_a), sx(out_i_a), era, eia);
            end
        end
        ncmp++;
        if (out_valid_b !== evb) begin
            nerr++;
            $display("FAIL valid_b got %0b want %0b", out_valid_b, evb);
        end else if (evb) begin
            ncmp++;
            if (sx(out_r_b) !== erb || sx(out_i_b) !== eib) begin
                nerr++;
                $display("FAIL data_b got (%0d,%0d) want (%0d,%0d)",
                         sx(out_r_b), sx(out_i_b), erb, eib);
            end
        end
        ova = out_valid_a;
        ora = sx(out_r_a);
        oia = sx(out_i_a);
    endtask

    task automatic check_zero(input string tag);
        ncmp++;
        if (out_valid_a !== 1'b0 || out_r_a !== 16'd0 ||
            out_i_a !== 16'd0 || out_valid_b !== 1'b0 ||
            out_r_b !== 16'd0 || out_i_b !== 16'd0) begin
            nerr++;
            $display("FAIL %s got a=%0b/%0d/%0d b=%0b/%0d/%0d want zeros",
                     tag, out_valid_a, sx(out_r_a), sx(out_i_a),
                     out_valid_b, sx(out_r_b), sx(out_i_b));
        end
        ncmp++;
        if (tw_idx_a !== 2'd0 || tw_idx_b !== 5'd0) begin
            nerr++;
            $display("FAIL %s tw_idx got %0d/%0d want 0/0",
                     tag, tw_idx_a, tw_idx_b);
        end
    endtask

    // Async pulse placed between edges; in_valid low so nothing is taken.
    task automatic pulse_reset(input string tag);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1 check_zero(tag);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        n_acc = 0;
    endtask

    task automatic set_rom_a_basic();
        rom_ar[0] = 8'sd64; rom_ai[0] = 8'sd0;
        rom_ar[1] = 8'sd0;  rom_ai[1] = -8'sd64;
        rom_ar[2] = 8'sd0;  rom_ai[2] = 8'sd0;
        rom_ar[3] = 8'sd0;  rom_ai[3] = 8'sd0;
    endtask

    task automatic randomize_roms();
        for (int k = 0; k < 4; k++) begin
            rom_ar[k] = 8'($signed($urandom_range(0, 90)) - 45);
            rom_ai[k] = 8'($signed($urandom_range(0, 90)) - 45);
        end
        for (int k = 0; k < 32; k++) begin
            rom_br[k] = 8'($signed($urandom_range(0, 90)) - 45);
            rom_bi[k] = 8'($signed($urandom_range(0, 90)) - 45);
        end
        rom_ar[0] = 8'sd64; rom_ai[0] = 8'sd0;
        rom_br[0] = 8'sd64; rom_bi[0] = 8'sd0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_r = '0;
        in_i = '0;
        inv = 1'b0;
        #1 check_zero("reset_state");
        @(posedge clk);
        #1 rst = 1'b0;
        n_acc = 0;
    endtask

    // 1,2,3,4,0,0,0,0 through the 4-point stage.
    task automatic test_basic(input bit iv, input bit toggle);
        int vr [8] = '{1, 2, 3, 4, 0, 0, 0, 0};
        bit evv [8] = '{0, 0, 1, 1, 1, 1, 1, 1};
        int er [8] = '{0, 0, 4, 6, -2, 0, 0, 0};
        int ei [8] = '{0, 0, 0, 0, 0, 2, 0, 0};
        bit ov, cur;
        int orr, oii;
        set_rom_a_basic();
        if (iv) ei[5] = -2;
        for (int k = 0; k < 8; k++) begin
            cur = iv;
            if (toggle && (k == 1 || k == 5)) cur = ~iv;
            cycle(1'b1, vr[k], 0, cur, ov, orr, oii);
            ncmp++;
            if (ov !== evv[k]) begin
                nerr++;
                $display("FAIL basic_valid[%0d] got %0b want %0b",
                         k, ov, evv[k]);
            end else if (evv[k]) begin
                ncmp++;
                if (orr !== er[k] || oii !== ei[k]) begin
                    nerr++;
                    $display("FAIL basic_out[%0d] got (%0d,%0d) want (%0d,%0d)",
                             k, orr, oii, er[k], ei[k]);
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_stall();
        bit sv [12] = '{1, 1, 0, 0, 0, 1, 1, 1, 0, 1, 1, 1};
        int sr [12] = '{1, 2, 9, 9, 9, 3, 4, 0, 7, 0, 0, 0};
        int er [6] = '{4, 6, -2, 0, 0, 0};
        int ei [6] = '{0, 0, 0, 2, 0, 0};
        int gr [12];
        int gi [12];
        int gcnt = 0;
        bit ov;
        int orr, oii;
        set_rom_a_basic();
        for (int k = 0; k < 12; k++) begin
            cycle(sv[k], sr[k], 0, 1'b0, ov, orr, oii);
            if (ov) begin
                gr[gcnt] = orr;
                gi[gcnt] = oii;
                gcnt++;
            end
        end
        in_valid = 1'b0;
        ncmp++;
        if (gcnt !== 6) begin
            nerr++;
            $display("FAIL stall_count got %0d want 6", gcnt);
        end else begin
            for (int k = 0; k < 6; k++) begin
                ncmp++;
                if (gr[k] !== er[k] || gi[k] !== ei[k]) begin
                    nerr++;
                    $display("FAIL stall_out[%0d] got (%0d,%0d) want (%0d,%0d)",
                             k, gr[k], gi[k], er[k], ei[k]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int vr [6] = '{1, 2, 3, 4, 0, 0};
        bit ov;
        int orr, oii;
        set_rom_a_basic();
        for (int k = 0; k < 6; k++) begin
            cycle(1'b1, vr[k], 0, 1'b0, ov, orr, oii);
        end
        ncmp++;
        if (out_valid_a !== 1'b1 || sx(out_i_a) !== 2) begin
            nerr++;
            $display("FAIL pre_reset got %0b/%0d want 1/2",
                     out_valid_a, sx(out_i_a));
        end
        in_valid = 1'b1;
        in_r = '0;
        in_i = '0;
        #2 rst = 1'b1;
        #1 check_zero("mid_reset");
        in_valid = 1'b0;
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        n_acc = 0;
        test_basic(1'b0, 1'b0);
    endtask

    task automatic test_round();
        bit ov;
        int orr, oii;
        rom_br[0] = 8'sd64; rom_bi[0] = 8'sd0;
        rom_br[1] = 8'sd45; rom_bi[1] = -8'sd45;
        for (int k = 0; k < 34; k++) begin
            cycle(1'b1, (k == 0 || k == 1) ? 16383 : 0, 0, 1'b0,
                  ov, orr, oii);
            if (k == 32) begin
                ncmp++;
                if (sx(out_r_b) !== 16383 || sx(out_i_b) !== 0) begin
                    nerr++;
                    $display("FAIL round_w0 got (%0d,%0d) want (16383,0)",
                             sx(out_r_b), sx(out_i_b));
                end
            end
            if (k == 33) begin
                ncmp++;
                if (sx(out_r_b) !== 11519 || sx(out_i_b) !== -11519) begin
                    nerr++;
                    $display("FAIL round_w1 got (%0d,%0d) want (11519,-11519)",
                             sx(out_r_b), sx(out_i_b));
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_extreme();
        bit ov;
        int orr, oii;
        for (int k = 0; k < 8; k++) begin
            cycle(1'b1, (k < 4) ? -16384 : 0, (k < 4) ? -16384 : 0,
                  1'b0, ov, orr, oii);
            if (k == 2 || k == 3) begin
                ncmp++;
                if (orr !== -32768 || oii !== -32768) begin
                    nerr++;
                    $display("FAIL extreme_sum[%0d] got (%0d,%0d) want -32768",
                             k, orr, oii);
                end
            end
            if (k == 4 || k == 5) begin
                ncmp++;
                if (ov !== 1'b1 || orr !== 0 || oii !== 0) begin
                    nerr++;
                    $display("FAIL extreme_diff[%0d] got %0b/(%0d,%0d) want 1/(0,0)",
                             k, ov, orr, oii);
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_random(input int ncyc);
        bit v, iv, ov;
        int r, i, orr, oii, sel;
        randomize_roms();
        iv = 1'b0;
        for (int k = 0; k < ncyc; k++) begin
            if (k == ncyc / 2) pulse_reset("rand_reset");
            v = ($urandom_range(0, 3) != 0);
            sel = $urandom_range(0, 7);
            r = $urandom_range(0, 32767) - 16384;
            i = $urandom_range(0, 32767) - 16384;
            if (sel == 0) r = -16384;
            if (sel == 1) i = 16383;
            if ($urandom_range(0, 9) == 0) iv = ~iv;
            cycle(v, r, i, iv, ov, orr, oii);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        randomize_roms();
        test_reset();
        test_basic(1'b0, 1'b0);
        pulse_reset("reset_b");
        test_basic(1'b1, 1'b1);
        pulse_reset("reset_c");
        test_stall();
        pulse_reset("reset_d");
        test_reset_mid();
        pulse_reset("reset_e");
        test_round();
        pulse_reset("reset_f");
        test_extreme();
        pulse_reset("reset_g");
        test_random(800);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nerr);
        $finish;
    end

endmodule
